// File: rtl/l2_sumsq_vec_pkg.sv
// Shared constants and types for the l2_sumsq_vec sum-of-squares engine.
// Holds the default widths, the counter-width helper and the pipeline valid bundle.
package l2_pkg;

  localparam int L2_IN_W    = 8;
  localparam int L2_ACC_W   = 20;
  localparam int L2_VEC_LEN = 4;

  // A one-element vector still needs a 1-bit counter to stay a legal vector.
  function automatic int l2_cnt_w(input int vec_len);
    return (vec_len <= 1) ? 1 : $clog2(vec_len);
  endfunction

  typedef struct packed {
    logic v0;
    logic v1;
  } l2_valid_t;

endpackage

// File: rtl/l2_sumsq_vec_sq_stage.sv
// Input capture and squaring stages of l2_sumsq_vec.
// It registers the element, squares it into an unsigned 2*IN_W product and carries the valids along.
module l2_sq_stage
  import l2_pkg::*;
#(
  parameter int IN_W = L2_IN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IN_W-1:0]   i_a,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic [2*IN_W-1:0] o_p,
  output logic              o_v1
);

  logic [IN_W-1:0]          r_a;
  logic [2*IN_W-1:0]        r_p;
  l2_valid_t                r_vld;
  logic signed [2*IN_W-1:0] w_a_ext;
  logic signed [2*IN_W-1:0] w_sq;

  // A square is never negative and (-2^(IN_W-1))^2 still fits 2*IN_W bits unsigned.
  assign w_a_ext = {{IN_W{r_a[IN_W-1]}}, r_a};
  assign w_sq    = w_a_ext * w_a_ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a      <= '0;
      r_p      <= '0;
      r_vld.v0 <= 1'b0;
      r_vld.v1 <= 1'b0;
    end else begin
      if (i_valid) r_a <= i_a;
      // A clear drops the element already in S0; one arriving with the clear starts the new vector.
      r_vld.v0 <= i_valid;
      r_vld.v1 <= r_vld.v0 & ~i_clear;
      r_p      <= w_sq;
    end
  end

  assign o_p  = r_p;
  assign o_v1 = r_vld.v1;

endmodule

// File: rtl/l2_sumsq_vec.sv
// Pipelined squared-L2-norm engine: one signed element per valid_in, one result per VEC_LEN elements.
// Define L2_SUMSQ_SAT_EN to clamp an overflowing vector to all-ones instead of wrapping.
module l2_sumsq_vec
  import l2_pkg::*;
#(
  parameter int IN_W    = L2_IN_W,
  parameter int ACC_W   = L2_ACC_W,
  parameter int VEC_LEN = L2_VEC_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic             valid_in,
  input  logic             clear,
  output logic [ACC_W-1:0] g,
  output logic             valid_out,
  output logic             overflow
);

  localparam int               CNT_W = l2_cnt_w(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(VEC_LEN - 1);

  if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
    $error("l2_sumsq_vec: ACC_W must be at least 2*IN_W");
  end
  if (VEC_LEN < 1) begin : g_bad_vec_len
    $error("l2_sumsq_vec: VEC_LEN must be at least 1");
  end

  logic [2*IN_W-1:0] w_p;
  logic              w_v1;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_ovf_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sticky;
  logic [ACC_W-1:0]  r_g;
  logic              r_ovf;
  logic              r_vo;

  l2_sq_stage #(
    .IN_W (IN_W)
  ) u_sq (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_a     (a),
    .i_valid (valid_in),
    .i_clear (clear),
    .o_p     (w_p),
    .o_v1    (w_v1)
  );

  // The extra sum bit is the carry-out that marks the vector as overflowed.
  always_comb begin
    w_sum     = (ACC_W + 1)'(r_acc) + (ACC_W + 1)'(w_p);
    w_acc_nxt = ACC_W'(w_p);
    w_ovf_nxt = 1'b0;
    if (r_cnt != '0) begin
      w_ovf_nxt = r_sticky | w_sum[ACC_W];
`ifdef L2_SUMSQ_SAT_EN
      w_acc_nxt = w_ovf_nxt ? '1 : w_sum[ACC_W-1:0];
`else
      w_acc_nxt = w_sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_g      <= '0;
      r_ovf    <= 1'b0;
      r_vo     <= 1'b0;
    end else begin
      r_vo <= 1'b0;
      if (clear) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_sticky <= 1'b0;
      end else if (w_v1) begin
        r_acc    <= w_acc_nxt;
        r_sticky <= w_ovf_nxt;
        if (r_cnt == LAST) begin
          r_cnt <= '0;
          r_g   <= w_acc_nxt;
          r_ovf <= w_ovf_nxt;
          r_vo  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign g         = r_g;
  assign overflow  = r_ovf;
  assign valid_out = r_vo;

endmodule

// File: tb/tb_l2_sumsq_vec.sv
// Self-checking bench for l2_sumsq_vec: default (ACC_W=20) and ACC_W=16 instances share one stimulus.
// A queue-based model predicts every output cycle; directed tests also pin literal results.
module tb_l2_sumsq_vec;

  localparam int VL = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       a_in = '0;
  logic             valid_in = 1'b0;
  logic             clear = 1'b0;
  logic [19:0]      g20;
  logic             vo20, ovf20;
  logic [15:0]      g16;
  logic             vo16, ovf16;

  int n_checks = 0;
  int n_err = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  l2_sumsq_vec u_dut20 (
    .clk(clk), .reset(reset), .a(a_in), .valid_in(valid_in), .clear(clear),
    .g(g20), .valid_out(vo20), .overflow(ovf20)
  );

  l2_sumsq_vec #(.IN_W(8), .ACC_W(16), .VEC_LEN(VL)) u_dut16 (
    .clk(clk), .reset(reset), .a(a_in), .valid_in(valid_in), .clear(clear),
    .g(g16), .valid_out(vo16), .overflow(ovf16)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic longint exp_g(input longint s, input int w);
    longint m;
    m = longint'(1) << w;
    if (s >= m) begin
`ifdef L2_SUMSQ_SAT_EN
      return m - 1;
`else
      return s % m;
`endif
    end
    return s;
  endfunction

  // Reference model: an element sampled at edge k is accounted at edge k+2 unless a clear intervenes.
  typedef struct {
    int     val;
    longint edge_n;
  } pend_t;

  pend_t  pend[$];
  int     vec[$];
  longint edge_cnt = 0;
  logic        exp_vo = 1'b0;
  logic [19:0] exp_g20 = '0;
  logic        exp_ovf20 = 1'b0;
  logic [15:0] exp_g16 = '0;
  logic        exp_ovf16 = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      vec.delete();
      edge_cnt  = 0;
      exp_vo    = 1'b0;
      exp_g20   = '0;
      exp_ovf20 = 1'b0;
      exp_g16   = '0;
      exp_ovf16 = 1'b0;
    end else begin
      pend_t  p;
      longint s;
      edge_cnt++;
      exp_vo = 1'b0;
      if (clear) begin
        pend.delete();
        vec.delete();
      end else begin
        while (pend.size() > 0 && pend[0].edge_n + 2 == edge_cnt) begin
          p = pend.pop_front();
          vec.push_back(p.val);
          if (vec.size() == VL) begin
            s = 0;
            foreach (vec[i]) s += longint'(vec[i]) * longint'(vec[i]);
            exp_vo    = 1'b1;
            exp_g20   = 20'(exp_g(s, 20));
            exp_ovf20 = (s >= (longint'(1) << 20));
            exp_g16   = 16'(exp_g(s, 16));
            exp_ovf16 = (s >= (longint'(1) << 16));
            vec.delete();
          end
        end
      end
      if (valid_in) begin
        p.val    = int'($signed(a_in));
        p.edge_n = edge_cnt;
        pend.push_back(p);
      end
    end
  end

  always @(negedge clk) begin
    chk("vo20", vo20, exp_vo);
    chk("g20", g20, exp_g20);
    chk("ovf20", ovf20, exp_ovf20);
    chk("vo16", vo16, exp_vo);
    chk("g16", g16, exp_g16);
    chk("ovf16", ovf16, exp_ovf16);
    if (vo20) pulses++;
  end

  task automatic send(input int v);
    @(negedge clk);
    valid_in = 1'b1;
    clear    = 1'b0;
    a_in     = 8'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      clear    = 1'b0;
      a_in     = 8'd127;
    end
  endtask

  initial begin
    int p0;
    int vA[4];
    int vB[4];
    vA = '{3, -4, 5, -1};
    vB = '{1, 2, 3, 4};

    @(negedge clk);
    reset = 1'b0;
    idle(10);
    chk("idle_g20", g20, 0);
    chk("idle_pulses", pulses, 0);

    // Back-to-back vectors.
    for (int i = 0; i < 4; i++) send(vA[i]);
    for (int i = 0; i < 4; i++) send(vB[i]);
    idle(2);
    chk("vecA_g20", g20, 51);
    chk("vecA_model", exp_g20, 51);
    idle(2);
    chk("vecB_g20", g20, 30);
    chk("vecB_g16", g16, 30);
    chk("vecB_ovf", ovf20, 0);

    // Same vector with gaps of 1..3 cycles.
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      send(vA[i]);
      idle(1 + (i % 3));
    end
    idle(4);
    chk("gap_g20", g20, 51);
    chk("gap_pulses", pulses - p0, 1);

    // Abort a partial vector; the element sent with clear starts a new one.
    p0 = pulses;
    send(10);
    send(10);
    @(negedge clk);
    valid_in = 1'b1;
    clear    = 1'b1;
    a_in     = 8'd1;
    idle(4);
    chk("clr_hold_g20", g20, 51);
    chk("clr_no_pulse", pulses - p0, 0);
    for (int i = 0; i < 3; i++) send(1);
    idle(4);
    chk("clr_g20", g20, 4);
    chk("clr_pulses", pulses - p0, 1);

    // Overflow on the 16-bit instance.
    for (int i = 0; i < 4; i++) send(-128);
    idle(4);
`ifdef L2_SUMSQ_SAT_EN
    chk("ovf_g16", g16, 65535);
`else
    chk("ovf_g16", g16, 0);
`endif
    chk("ovf_flag16", ovf16, 1);
    chk("ovf_g20", g20, 65536);
    chk("ovf_flag20", ovf20, 0);
    for (int i = 0; i < 4; i++) send(1);
    idle(4);
    chk("after_ovf_g16", g16, 4);
    chk("after_ovf_flag16", ovf16, 0);

    // Asynchronous reset mid-vector.
    send(9);
    send(9);
    @(negedge clk);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_g20", g20, 0);
    chk("rst_vo20", vo20, 0);
    chk("rst_ovf16", ovf16, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(2);
    idle(4);
    chk("rst_then_g20", g20, 16);
    chk("rst_then_g16", g16, 16);

    // Randomized traffic with occasional clears and large magnitudes.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      valid_in = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 40) == 0);
      a_in     = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(120, 136));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/l2_sumsq_vec.md
Name: l2_sumsq_vec

Overview:
- Parametrised pipelined sum-of-squares engine. Computes the squared L2 norm of signed input vectors of VEC_LEN elements.
- Streams one element per valid_in, with arbitrary bubbles between elements.
- Emits one result per completed vector with a one-cycle valid_out and a per-vector overflow flag.
- Next-generation replacement for the single-accumulator MAC stage in the L2-norm datapath.

Parameters:
- IN_W, 8, width of signed input element a.
- ACC_W, 20, accumulator/result width. Elaboration error unless ACC_W >= 2*IN_W.
- VEC_LEN, 4, elements per vector. Elaboration error unless VEC_LEN >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- a  input  IN_W  signed element; sampled only when valid_in=1.
- valid_in  input  1  element-valid qualifier.
- clear  input  1  synchronous abort of the partial vector.
- g  output  ACC_W  unsigned sum of squares of the last completed vector.
- valid_out  output  1  one-cycle pulse; g and overflow are new this cycle.
- overflow  output  1  set if the last completed vector overflowed ACC_W.

Behaviour:
- Reset: all outputs and internal registers go to 0 asynchronously while reset=1, including g, valid_out, overflow, element counter, pipeline valids and sticky overflow.
- Pipeline, 3 register stages:
  - S0: a_r <= a and v0 <= valid_in. a_r loads only when valid_in=1.
  - S1: p <= a_r*a_r as an unsigned 2*IN_W product, v1 <= v0.
  - S2: accumulate when v1=1.
- Latency: an element sampled at edge E contributes at edge E+2. For the last element, valid_out is high for exactly the cycle after edge E+2.
- Cycles with valid_in=0 are ignored entirely. Data on a is don't-care, and the count does not advance.
- S2 counter cnt runs 0..VEC_LEN-1 on v1:
  - cnt==0: acc = p, ovf_sticky = 0.
  - Otherwise: acc = acc + p, computed ACC_W+1 wide; a carry-out sets ovf_sticky.
  - cnt==VEC_LEN-1: g <= final sum, overflow <= final sticky, valid_out <= 1, cnt <= 0.
  - VEC_LEN=1: every element completes a vector.
- g and overflow hold their values between valid_out pulses. valid_out is 0 otherwise.
- Back-to-back vectors with no gap are supported, giving one result every VEC_LEN valid cycles.
- clear=1: v0, v1, cnt, acc and ovf_sticky are zeroed at that edge, so in-flight elements are discarded. g and overflow keep their last completed values, and valid_out does not fire.
- clear and valid_in together: the element on a is captured by S0 and becomes element 0 of a new vector.
- Reset mid-vector: the partial sum is discarded. The next valid element is element 0.
- Non-saturating overflow: the sum wraps modulo 2^ACC_W.

Optional Feature:
- Macro: L2_SUMSQ_SAT_EN.
- Defined: on carry-out, acc clamps to all-ones (2^ACC_W-1) and stays clamped for the rest of the vector. overflow is still reported.
- Undefined: wrap-around as above, with overflow reported.

Decomposition:
- Package l2_pkg:
  - default parameter constants: L2_IN_W=8, L2_ACC_W=20, L2_VEC_LEN=4.
  - function for counter width, $clog2(VEC_LEN) with a minimum of 1.
  - typedef for the pipeline valid bundle.
- One sub-module, l2_sq_stage: stages S0/S1, with input register and squarer plus valid propagation.
- Top level: owns the counter, accumulator, overflow logic and the output registers.

Test Plan:
- Reset released after 1 cycle, no stimulus. Required: g=0, valid_out=0, overflow=0 for 10 cycles.
- Contiguous vector {3,-4,5,-1} with defaults. Required: one valid_out pulse 2 edges after the last sample, g=51, overflow=0. Repeat immediately with {1,2,3,4}: g=30 exactly 4 cycles later.
- Same {3,-4,5,-1} with valid_in gaps of 1-3 cycles, a=127 during gaps. Required: g=51, and valid_out fires only once.
- ACC_W=16 instance, vector {-128,-128,-128,-128}. Required: g=0 and overflow=1 without the macro; g=65535 and overflow=1 with L2_SUMSQ_SAT_EN. Next vector {1,1,1,1}: g=4, overflow=0.
- Send elements {10,10}, then pulse clear together with valid_in a=1, then send {1,1,1}. Required: no valid_out for the aborted part, then g=4. Previous g is unchanged before that.
- Assert reset asynchronously mid-vector after 2 elements, then send {2,2,2,2}. Required: all outputs 0 immediately on reset, then g=16.
